// File: rtl/alu_issue_queue.sv
// Collapsing age-ordered ALU/BRU issue queue with writeback wakeup.
// Optional same-cycle wakeup bypass into select: ALU_IQ_WAKE_BYPASS_EN.
package uopc;
    typedef enum logic [4:0] {
        UOP_NOP, UOP_ADD, UOP_ADDI, UOP_SUB, UOP_AND, UOP_OR,
        UOP_XOR, UOP_SLL, UOP_SRL, UOP_SRA, UOP_SLT, UOP_SLTU,
        UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR, UOP_BEQ, UOP_BNE,
        UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU
    } micro_opcode_t;
endpackage

package immt;
    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;
endpackage

module alu_issue_queue #(
    parameter int DEPTH    = 8,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 5,
    parameter int WB_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  uopc::micro_opcode_t          enq_uopcode,
    input  logic [19:0]                  enq_packed_imm,
    input  immt::imm_type_t              enq_imm_type,
    input  logic [PREG_W-1:0]            enq_prs1,
    input  logic [PREG_W-1:0]            enq_prs2,
    input  logic                         enq_prs1_busy,
    input  logic                         enq_prs2_busy,
    input  logic [PREG_W-1:0]            enq_pdst,
    input  logic [ROB_W-1:0]             enq_rob_idx,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]   wb_pdst,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output uopc::micro_opcode_t          iss_uopcode,
    output logic [19:0]                  iss_packed_imm,
    output immt::imm_type_t              iss_imm_type,
    output logic [PREG_W-1:0]            iss_prs1,
    output logic [PREG_W-1:0]            iss_prs2,
    output logic [PREG_W-1:0]            iss_pdst,
    output logic [ROB_W-1:0]             iss_rob_idx,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        uopc::micro_opcode_t uopcode;
        logic [19:0]         packed_imm;
        immt::imm_type_t     imm_type;
        logic [PREG_W-1:0]   prs1;
        logic [PREG_W-1:0]   prs2;
        logic [PREG_W-1:0]   pdst;
        logic [ROB_W-1:0]    rob_idx;
        logic                busy1;
        logic                busy2;
    } entry_t;

    entry_t        q   [DEPTH];
    entry_t        nxt [DEPTH];
    logic [CW-1:0] cnt;
    logic [DEPTH-1:0] rdy;
    logic [IW-1:0] sel_idx;
    logic          any_rdy;
    logic          enq_fire;
    logic          iss_fire;
    logic [CW-1:0] wr_idx;

    // Tag 0 is hardwired ready, so it never counts as a wakeup hit.
    function automatic logic wb_hit(input logic [PREG_W-1:0] tag,
                                    input logic [WB_PORTS-1:0] v,
                                    input logic [WB_PORTS*PREG_W-1:0] p);
        logic h;
        h = 1'b0;
        for (int i = 0; i < WB_PORTS; i++)
            if (v[i] && p[i*PREG_W +: PREG_W] == tag && tag != '0)
                h = 1'b1;
        return h;
    endfunction

    always_comb begin
        rdy = '0;
        for (int j = 0; j < DEPTH; j++) begin
`ifdef ALU_IQ_WAKE_BYPASS_EN
            rdy[j] = (j < int'(cnt))
                   & !(q[j].busy1 & !wb_hit(q[j].prs1, wb_valid, wb_pdst))
                   & !(q[j].busy2 & !wb_hit(q[j].prs2, wb_valid, wb_pdst));
`else
            rdy[j] = (j < int'(cnt)) & !q[j].busy1 & !q[j].busy2;
`endif
        end
    end

    always_comb begin
        sel_idx = '0;
        any_rdy = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (!any_rdy && rdy[j]) begin
                sel_idx = IW'(j);
                any_rdy = 1'b1;
            end
        end
    end

    assign enq_ready = (cnt != CW'(DEPTH));
    assign iss_valid = any_rdy & !flush;
    assign iss_fire  = iss_valid & iss_ready;
    assign enq_fire  = enq_valid & enq_ready & !flush;
    assign wr_idx    = cnt - CW'(iss_fire);
    assign count     = cnt;

    assign iss_uopcode    = iss_valid ? q[sel_idx].uopcode : uopc::UOP_NOP;
    assign iss_packed_imm = iss_valid ? q[sel_idx].packed_imm : '0;
    assign iss_imm_type   = iss_valid ? q[sel_idx].imm_type : immt::IMM_I;
    assign iss_prs1       = iss_valid ? q[sel_idx].prs1 : '0;
    assign iss_prs2       = iss_valid ? q[sel_idx].prs2 : '0;
    assign iss_pdst       = iss_valid ? q[sel_idx].pdst : '0;
    assign iss_rob_idx    = iss_valid ? q[sel_idx].rob_idx : '0;

    // Collapse first, then wake the shifted entries, then append.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            nxt[j] = q[j];
            if (iss_fire && j < DEPTH - 1 && j >= int'(sel_idx))
                nxt[j] = q[j+1];
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (wb_hit(nxt[j].prs1, wb_valid, wb_pdst))
                nxt[j].busy1 = 1'b0;
            if (wb_hit(nxt[j].prs2, wb_valid, wb_pdst))
                nxt[j].busy2 = 1'b0;
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (enq_fire && j == int'(wr_idx)) begin
                nxt[j].uopcode    = enq_uopcode;
                nxt[j].packed_imm = enq_packed_imm;
                nxt[j].imm_type   = enq_imm_type;
                nxt[j].prs1       = enq_prs1;
                nxt[j].prs2       = enq_prs2;
                nxt[j].pdst       = enq_pdst;
                nxt[j].rob_idx    = enq_rob_idx;
                nxt[j].busy1      = enq_prs1_busy & (enq_prs1 != '0)
                                  & !wb_hit(enq_prs1, wb_valid, wb_pdst);
                nxt[j].busy2      = enq_prs2_busy & (enq_prs2 != '0)
                                  & !wb_hit(enq_prs2, wb_valid, wb_pdst);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int j = 0; j < DEPTH; j++)
                q[j] <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(enq_fire) - CW'(iss_fire);
            for (int j = 0; j < DEPTH; j++)
                q[j] <= nxt[j];
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed-vector bench for alu_issue_queue.
// Covers both builds of ALU_IQ_WAKE_BYPASS_EN.
module tb_alu_issue_queue;
    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                enq_valid;
    logic                enq_ready;
    uopc::micro_opcode_t enq_uopcode;
    logic [19:0]         enq_packed_imm;
    immt::imm_type_t     enq_imm_type;
    logic [5:0]          enq_prs1, enq_prs2, enq_pdst;
    logic                enq_prs1_busy, enq_prs2_busy;
    logic [4:0]          enq_rob_idx;
    logic [1:0]          wb_valid;
    logic [11:0]         wb_pdst;
    logic                iss_valid;
    logic                iss_ready;
    uopc::micro_opcode_t iss_uopcode;
    logic [19:0]         iss_packed_imm;
    immt::imm_type_t     iss_imm_type;
    logic [5:0]          iss_prs1, iss_prs2, iss_pdst;
    logic [4:0]          iss_rob_idx;
    logic [3:0]          count;

    int vecs = 0;
    int errs = 0;

    alu_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_uopcode(enq_uopcode), .enq_packed_imm(enq_packed_imm),
        .enq_imm_type(enq_imm_type),
        .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_prs1_busy(enq_prs1_busy), .enq_prs2_busy(enq_prs2_busy),
        .enq_pdst(enq_pdst), .enq_rob_idx(enq_rob_idx),
        .wb_valid(wb_valid), .wb_pdst(wb_pdst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_uopcode(iss_uopcode), .iss_packed_imm(iss_packed_imm),
        .iss_imm_type(iss_imm_type),
        .iss_prs1(iss_prs1), .iss_prs2(iss_prs2),
        .iss_pdst(iss_pdst), .iss_rob_idx(iss_rob_idx),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; enq_valid = 0; enq_uopcode = uopc::UOP_NOP;
        enq_packed_imm = 0; enq_imm_type = immt::IMM_I;
        enq_prs1 = 0; enq_prs2 = 0; enq_prs1_busy = 0; enq_prs2_busy = 0;
        enq_pdst = 0; enq_rob_idx = 0; wb_valid = 0; wb_pdst = 0;
    endtask

    task automatic set_enq(input logic [5:0] p1, input logic b1,
                           input logic [5:0] p2, input logic b2,
                           input logic [4:0] rob);
        enq_valid = 1; enq_uopcode = uopc::UOP_ADDI;
        enq_packed_imm = 20'h00123; enq_imm_type = immt::IMM_I;
        enq_prs1 = p1; enq_prs1_busy = b1;
        enq_prs2 = p2; enq_prs2_busy = b2;
        enq_pdst = 6'(rob) + 6'd32; enq_rob_idx = rob;
    endtask

    task automatic test_reset();
        idle(); iss_ready = 0; rst = 0;
        #3;
        vecs++; if (count !== 4'd0) begin errs++;
            $display("FAIL reset_count: got %0d want 0", count); end
        vecs++; if (enq_ready !== 1'b1) begin errs++;
            $display("FAIL reset_enq_ready: got %0b want 1", enq_ready); end
        vecs++; if (iss_valid !== 1'b0) begin errs++;
            $display("FAIL reset_iss_valid: got %0b want 0", iss_valid); end
        vecs++; if (iss_rob_idx !== 5'd0 || iss_pdst !== 6'd0) begin errs++;
            $display("FAIL reset_payload: got rob %0d pdst %0d want 0",
                     iss_rob_idx, iss_pdst); end
        tick(); tick();
        rst = 1;
        tick();
    endtask

    task automatic test_in_order();
        iss_ready = 1;
        set_enq(0, 0, 0, 0, 0);
        #1;
        vecs++; if (iss_valid !== 1'b0) begin errs++;
            $display("FAIL order_c0_valid: got %0b want 0", iss_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) set_enq(0, 0, 0, 0, 5'(k + 1)); else idle();
            #1;
            vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'(k)) begin
                errs++;
                $display("FAIL order_issue%0d: got v=%0b rob=%0d want v=1 rob=%0d",
                         k, iss_valid, iss_rob_idx, k);
            end
            vecs++; if (count !== 4'd1) begin errs++;
                $display("FAIL order_count%0d: got %0d want 1", k, count); end
            if (k == 0) begin
                vecs++;
                if (iss_uopcode !== uopc::UOP_ADDI
                    || iss_packed_imm !== 20'h00123
                    || iss_imm_type !== immt::IMM_I
                    || iss_pdst !== 6'd32) begin
                    errs++;
                    $display("FAIL order_payload: got uop %0d imm %h pdst %0d want 2 00123 32",
                             iss_uopcode, iss_packed_imm, iss_pdst);
                end
            end
            tick();
        end
        vecs++; if (count !== 4'd0 || iss_valid !== 1'b0) begin errs++;
            $display("FAIL order_drain: got count %0d v %0b want 0 0",
                     count, iss_valid); end
    endtask

    task automatic test_full_wakeup();
        iss_ready = 1;
        for (int k = 0; k < 8; k++) begin
            set_enq(5, 1, 0, 0, 5'(k));
            tick();
        end
        idle();
        #1;
        vecs++; if (count !== 4'd8 || enq_ready !== 1'b0) begin errs++;
            $display("FAIL full_state: got count %0d rdy %0b want 8 0",
                     count, enq_ready); end
        vecs++; if (iss_valid !== 1'b0) begin errs++;
            $display("FAIL full_no_issue: got %0b want 0", iss_valid); end
        wb_valid = 2'b01; wb_pdst = {6'd0, 6'd5};
        #1;
`ifdef ALU_IQ_WAKE_BYPASS_EN
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd0) begin errs++;
            $display("FAIL wake_bypass: got v %0b rob %0d want 1 0",
                     iss_valid, iss_rob_idx); end
        tick();
        idle();
`else
        vecs++; if (iss_valid !== 1'b0) begin errs++;
            $display("FAIL wake_latency: got %0b want 0", iss_valid); end
        tick();
        idle();
        #1;
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd0
                    || enq_ready !== 1'b0) begin errs++;
            $display("FAIL wake_issue: got v %0b rob %0d rdy %0b want 1 0 0",
                     iss_valid, iss_rob_idx, enq_ready); end
        tick();
`endif
        vecs++; if (count !== 4'd7 || enq_ready !== 1'b1) begin errs++;
            $display("FAIL after_first: got count %0d rdy %0b want 7 1",
                     count, enq_ready); end
        for (int k = 1; k < 8; k++) begin
            vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'(k)) begin
                errs++;
                $display("FAIL drain%0d: got v %0b rob %0d want 1 %0d",
                         k, iss_valid, iss_rob_idx, k);
            end
            tick();
        end
        vecs++; if (count !== 4'd0) begin errs++;
            $display("FAIL full_drained: got %0d want 0", count); end
    endtask

    task automatic test_shift();
        iss_ready = 0;
        set_enq(7, 1, 0, 0, 10);
        tick();
        set_enq(0, 0, 0, 0, 11);
        tick();
        idle(); iss_ready = 1;
        #1;
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd11) begin errs++;
            $display("FAIL shift_b_first: got v %0b rob %0d want 1 11",
                     iss_valid, iss_rob_idx); end
        tick();
        vecs++; if (count !== 4'd1 || iss_valid !== 1'b0) begin errs++;
            $display("FAIL shift_a_wait: got count %0d v %0b want 1 0",
                     count, iss_valid); end
        wb_valid = 2'b10; wb_pdst = {6'd7, 6'd0};
        #1;
`ifdef ALU_IQ_WAKE_BYPASS_EN
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd10) begin errs++;
            $display("FAIL shift_a_bypass: got v %0b rob %0d want 1 10",
                     iss_valid, iss_rob_idx); end
        tick();
        idle();
`else
        tick();
        idle();
        #1;
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd10) begin errs++;
            $display("FAIL shift_a_issue: got v %0b rob %0d want 1 10",
                     iss_valid, iss_rob_idx); end
        tick();
`endif
        vecs++; if (count !== 4'd0) begin errs++;
            $display("FAIL shift_empty: got %0d want 0", count); end
    endtask

    task automatic test_full_collision();
        iss_ready = 0;
        for (int k = 0; k < 8; k++) begin
            set_enq(0, 0, 0, 0, 5'(k));
            tick();
        end
        iss_ready = 1;
        set_enq(0, 0, 0, 0, 20);
        #1;
        vecs++; if (enq_ready !== 1'b0 || iss_valid !== 1'b1) begin errs++;
            $display("FAIL coll_same_cycle: got rdy %0b v %0b want 0 1",
                     enq_ready, iss_valid); end
        tick();
        iss_ready = 0;
        #1;
        vecs++; if (count !== 4'd7 || enq_ready !== 1'b1) begin errs++;
            $display("FAIL coll_refused: got count %0d rdy %0b want 7 1",
                     count, enq_ready); end
        tick();
        idle();
        vecs++; if (count !== 4'd8) begin errs++;
            $display("FAIL coll_accept: got %0d want 8", count); end
        iss_ready = 1;
        for (int k = 0; k < 8; k++) tick();
        vecs++; if (count !== 4'd0) begin errs++;
            $display("FAIL coll_drain: got %0d want 0", count); end
    endtask

    task automatic test_enq_wake();
        iss_ready = 1;
        set_enq(0, 0, 9, 1, 5);
        wb_valid = 2'b01; wb_pdst = {6'd0, 6'd9};
        #1;
        vecs++; if (iss_valid !== 1'b0) begin errs++;
            $display("FAIL enqwake_same: got %0b want 0", iss_valid); end
        tick();
        idle();
        #1;
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd5
                    || iss_prs2 !== 6'd9) begin errs++;
            $display("FAIL enqwake_next: got v %0b rob %0d prs2 %0d want 1 5 9",
                     iss_valid, iss_rob_idx, iss_prs2); end
        tick();
        set_enq(0, 1, 0, 1, 6);
        tick();
        idle();
        #1;
        vecs++; if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd6) begin errs++;
            $display("FAIL tag0_ready: got v %0b rob %0d want 1 6",
                     iss_valid, iss_rob_idx); end
        tick();
        vecs++; if (count !== 4'd0) begin errs++;
            $display("FAIL tag0_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        iss_ready = 0;
        for (int k = 0; k < 5; k++) begin
            set_enq(0, 0, 0, 0, 5'(k));
            tick();
        end
        iss_ready = 1; flush = 1;
        set_enq(0, 0, 0, 0, 9);
        #1;
        vecs++; if (iss_valid !== 1'b0 || iss_rob_idx !== 5'd0) begin errs++;
            $display("FAIL flush_iss: got v %0b rob %0d want 0 0",
                     iss_valid, iss_rob_idx); end
        tick();
        idle();
        #1;
        vecs++; if (count !== 4'd0 || iss_valid !== 1'b0
                    || enq_ready !== 1'b1) begin errs++;
            $display("FAIL flush_after: got count %0d v %0b rdy %0b want 0 0 1",
                     count, iss_valid, enq_ready); end
    endtask

    task automatic test_async_reset();
        iss_ready = 0;
        set_enq(0, 0, 0, 0, 3);
        tick();
        set_enq(0, 0, 0, 0, 4);
        tick();
        idle();
        #1;
        vecs++; if (iss_valid !== 1'b1 || count !== 4'd2) begin errs++;
            $display("FAIL arst_pre: got v %0b count %0d want 1 2",
                     iss_valid, count); end
        rst = 0;
        #1;
        vecs++; if (iss_valid !== 1'b0 || count !== 4'd0
                    || iss_rob_idx !== 5'd0 || enq_ready !== 1'b1) begin errs++;
            $display("FAIL arst_now: got v %0b count %0d rob %0d rdy %0b want 0 0 0 1",
                     iss_valid, count, iss_rob_idx, enq_ready); end
        tick();
        rst = 1;
        tick();
        vecs++; if (count !== 4'd0 || iss_valid !== 1'b0) begin errs++;
            $display("FAIL arst_after: got count %0d v %0b want 0 0",
                     count, iss_valid); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wakeup();
        test_shift();
        test_full_collision();
        test_enq_wake();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Collapsing, age-ordered issue queue for ALU/BRU micro-ops, directly upstream of the register-read/execute-decode stage.
- Accepts renamed uops from dispatch and tracks operand readiness via writeback tag broadcasts.
- Issues the oldest ready uop per cycle over a valid/ready handshake to register read.
- Carries uopcode and packed immediate unchanged; decode into ALU/branch controls and a 32-bit immediate happens downstream.

Parameters:
- DEPTH, 8, number of entries (power of 2 not required, >=2).
- PREG_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.
- WB_PORTS, 2, number of writeback wakeup broadcast ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- flush  in  1  synchronous squash of all entries.
- enq_valid  in  1  dispatch offers a uop.
- enq_ready  out  1  queue can accept.
- enq_uopcode  in  uopc::micro_opcode_t  micro-opcode.
- enq_packed_imm  in  20  packed immediate.
- enq_imm_type  in  immt::imm_type_t  immediate format.
- enq_prs1, enq_prs2  in  PREG_W each  source tags.
- enq_prs1_busy, enq_prs2_busy  in  1 each  source not yet produced.
- enq_pdst  in  PREG_W  destination tag.
- enq_rob_idx  in  ROB_W  ROB index.
- wb_valid  in  WB_PORTS  wakeup valid per port.
- wb_pdst  in  WB_PORTS*PREG_W  wakeup tags, port i at [i*PREG_W +: PREG_W].
- iss_valid  out  1  issue candidate present.
- iss_ready  in  1  register read accepts.
- iss_uopcode, iss_packed_imm, iss_imm_type, iss_prs1, iss_prs2, iss_pdst, iss_rob_idx  out  same widths as enq_*  selected uop payload.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst=0, asynchronous): all entries invalid, count=0, enq_ready=1, iss_valid=0. Issue payload outputs are 0 whenever iss_valid=0, including during reset.
- Storage: entries 0..count-1 valid, index 0 oldest. Each entry holds the payload plus busy1/busy2.
- Enqueue: fires when enq_valid & enq_ready.
  - enq_ready = (count != DEPTH); it depends on registered state only. No pass-through when full, even if an issue fires the same cycle.
  - The entry is written at index count, or count-1 if an issue fires the same cycle.
- Stored busy bit = enq_busy & (tag != 0) & no same-cycle wb match. Tag 0 is always ready.
- Wakeup: for every valid entry and every port i with wb_valid[i] and wb_pdst[i]==tag, clear the matching busy bit at the clock edge. This applies to entries after any collapse shift. A wb of tag 0 has no effect.
- Ready condition: entry is ready when valid & !busy1 & !busy2, using registered busy bits.
  - A wakeup in cycle t makes the entry selectable in t+1.
  - An entry enqueued in cycle t is selectable no earlier than t+1.
- Select: iss_valid = any ready entry & !flush. Payload comes from the lowest-index ready entry, combinationally from registered state.
- Issue: fires when iss_valid & iss_ready. The selected entry k is removed; entries k+1..count-1 shift down by one in the same edge and count decrements. With no iss_ready, the payload is held stable while the selection is unchanged. An older entry becoming ready may displace the current candidate; the handshake permits this.
- Simultaneous enq+issue: count unchanged; the new entry lands at old count-1.
- Flush: on the next edge all entries are invalid and count=0. Flush has priority over enq and issue; enq_ready stays as computed but the enqueue is dropped.
- Reset mid-operation: asynchronously clears everything, identical to the reset state.

Optional Feature:
- Macro ALU_IQ_WAKE_BYPASS_EN.
- Defined: the ready condition also treats an operand as not busy when it matches a same-cycle wb_valid/wb_pdst. A wakeup in cycle t lets the entry issue in cycle t, including an entry whose last busy operand is woken in t.
- Undefined: one-cycle wakeup-to-select latency as specified above.
- Enqueue-to-select latency is 1 in both builds.

Test Plan:
- Reset, enqueue 3 addi with prs=0 over 3 cycles, iss_ready=1 -> iss_valid from cycle 1; issues in order; rob_idx 0,1,2; count returns to 0.
- Fill 8 entries with busy prs1=5, iss_ready=1 -> enq_ready=0 at count=8 and no issue. wb_valid[0]=1, wb_pdst=5 in cycle t -> all ready; entry 0 issues at t+1 (t with ALU_IQ_WAKE_BYPASS_EN). enq_ready=1 the cycle after first issue.
- Entries A(busy prs1=7) and B(ready), iss_ready=1 -> B issues first and A shifts to index 0. wb on port 1 with tag 7 -> A issues next cycle.
- Full queue, enq_valid=1, issue same cycle -> enqueue refused that cycle; count=7 next; enqueue accepted the following cycle.
- Enqueue with prs2=9 busy while wb_pdst=9 valid the same cycle -> entry stored ready, issues next cycle. Tag 0 marked busy -> treated ready.
- Flush with 5 entries and iss_ready=1 -> iss_valid=0 that cycle, no issue, count=0 next cycle. Async rst mid-run -> outputs 0 immediately.
